mem_access_stage: RTL and testbench

//  EX/MEM + MEM/WB pipeline stage directly downstream of the ALU.
//  - Registers ALU result and forwarded store data.
//  - Runs the data-memory request/ack handshake; forms byte enables and load extension.
//  - Detects misaligned accesses; enforces a bus timeout.
//  - Feeds the ALU forwarding inputs (MEMAlu, WB*) and the writeback mux.

---
 rtl/mem_access_stage.sv | 246 ++++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - EX/MEM + MEM/WB stage with dmem handshake, lane steering and bus timeout
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic [31:0] ex_pc,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_wen,
    input  logic [1:0]  ex_wbsel,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic        ex_csr_reg_en,
    input  logic [31:0] ex_csr_rresult,
    input  logic        flush,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic [31:0] MEMAlu,
    output logic        MEM_csr_reg_en,
    output logic [31:0] MEM_csr_rresult,
    output logic [31:0] WBdmem,
    output logic [31:0] WBAlu,
    output logic [31:0] WBPC,
    output logic [1:0]  WBSel,
    output logic        WB_csr_reg_en,
    output logic [31:0] WB_csr_rresult,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_wen,
    output logic        misalign_exc,
    output logic        bus_err,
    output logic [31:0] exc_addr
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        mem_valid_q, mem_reg_wen_q, mem_read_q, mem_write_q, mem_csr_en_q;
    logic [31:0] mem_alu_q, mem_store_q, mem_pc_q, mem_csr_val_q;
    logic [4:0]  mem_rd_q;
    logic [1:0]  mem_wbsel_q;
    logic [2:0]  mem_funct3_q;

    logic        wb_reg_wen_q, wb_csr_en_q;
    logic [31:0] wb_dmem_q, wb_alu_q, wb_pc_q, wb_csr_val_q, exc_addr_q;
    logic [4:0]  wb_rd_q;
    logic [1:0]  wb_sel_q;

    logic        mem_access, misaligned, memop, timeout;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // MEM register: advance from EX unless stalled; squashed or empty slots become bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid_q   <= 1'b0;
            mem_alu_q     <= '0;
            mem_store_q   <= '0;
            mem_pc_q      <= '0;
            mem_rd_q      <= '0;
            mem_reg_wen_q <= 1'b0;
            mem_wbsel_q   <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_funct3_q  <= '0;
            mem_csr_en_q  <= 1'b0;
            mem_csr_val_q <= '0;
        end else if (!mem_stall) begin
            mem_valid_q <= ex_valid & ~flush;
            if (ex_valid && !flush) begin
                mem_alu_q     <= ex_alu_result;
                mem_store_q   <= ex_store_data;
                mem_pc_q      <= ex_pc;
                mem_rd_q      <= ex_rd;
                mem_reg_wen_q <= ex_reg_wen;
                mem_wbsel_q   <= ex_wbsel;
                mem_read_q    <= ex_mem_read;
                mem_write_q   <= ex_mem_write;
                mem_funct3_q  <= ex_funct3;
                mem_csr_en_q  <= ex_csr_reg_en;
                mem_csr_val_q <= ex_csr_rresult;
            end
        end
    end

    // Halfwords need bit 0 clear, words need both low bits clear; bytes are always aligned
    assign mem_access = mem_valid_q & (mem_read_q | mem_write_q);
    assign misaligned = mem_access &
                        (((mem_funct3_q[1:0] == 2'b01) & mem_alu_q[0]) |
                         ((mem_funct3_q[1:0] == 2'b10) & (|mem_alu_q[1:0])));
    assign memop      = mem_access & ~misaligned;

    // FSM state and timeout counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake: same-cycle ack is zero-wait; otherwise stall in BUSY until ack or timeout
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_stall = 1'b0;
        timeout   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (memop && !dmem_ack) begin
                    mem_stall = 1'b1;
                    state_d   = S_BUSY;
                    cnt_d     = CNT_ONE;
                end
            end
            S_BUSY: begin
                if (!memop || dmem_ack) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_V) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    mem_stall = 1'b1;
                    cnt_d     = cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    // Store lane steering: replicate data across lanes and enable only the addressed bytes
    always_comb begin
        dmem_be    = 4'b0000;
        dmem_wdata = 32'h0;
        if (memop) begin
            if (mem_write_q) begin
                case (mem_funct3_q[1:0])
                    2'b00: begin
                        dmem_be    = 4'b0001 << mem_alu_q[1:0];
                        dmem_wdata = {4{mem_store_q[7:0]}};
                    end
                    2'b01: begin
                        dmem_be    = 4'b0011 << {mem_alu_q[1], 1'b0};
                        dmem_wdata = {2{mem_store_q[15:0]}};
                    end
                    default: begin
                        dmem_be    = 4'b1111;
                        dmem_wdata = mem_store_q;
                    end
                endcase
            end else begin
                dmem_be = 4'b1111;
            end
        end
    end

    // Load extraction: pick byte/half by address, then sign- or zero-extend
    always_comb begin
        ld_byte = dmem_rdata[7:0];
        case (mem_alu_q[1:0])
            2'b00: ld_byte = dmem_rdata[7:0];
            2'b01: ld_byte = dmem_rdata[15:8];
            2'b10: ld_byte = dmem_rdata[23:16];
            2'b11: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = mem_alu_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (mem_funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = dmem_rdata;
        endcase
    end

    assign dmem_req     = memop;
    assign dmem_we      = memop & mem_write_q;
    assign dmem_addr    = {mem_alu_q[31:2], 2'b00};
    assign misalign_exc = misaligned;
    assign bus_err      = timeout;
    assign exc_addr     = (misaligned | timeout) ? mem_alu_q : exc_addr_q;

    // Remember the last faulting address so it stays visible after the pulse
    always_ff @(posedge clk) begin
        if (rst) exc_addr_q <= '0;
        else     exc_addr_q <= exc_addr;
    end

    // WB register: advance when not stalled; a stall cycle inserts a write-disabled bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_reg_wen_q <= 1'b0;
            wb_rd_q      <= '0;
            wb_dmem_q    <= '0;
            wb_alu_q     <= '0;
            wb_pc_q      <= '0;
            wb_sel_q     <= '0;
            wb_csr_en_q  <= 1'b0;
            wb_csr_val_q <= '0;
        end else if (mem_stall) begin
            wb_reg_wen_q <= 1'b0;
        end else begin
            wb_reg_wen_q <= mem_valid_q & mem_reg_wen_q & ~misaligned & ~timeout;
            wb_rd_q      <= mem_rd_q;
            wb_alu_q     <= mem_alu_q;
            wb_pc_q      <= mem_pc_q;
            wb_sel_q     <= mem_wbsel_q;
            wb_csr_en_q  <= mem_csr_en_q;
            wb_csr_val_q <= mem_csr_val_q;
            if (memop && mem_read_q && dmem_ack)
                wb_dmem_q <= ld_ext;
        end
    end

    assign MEMAlu          = mem_alu_q;
    assign MEM_csr_reg_en  = mem_csr_en_q;
    assign MEM_csr_rresult = mem_csr_val_q;
    assign WBdmem          = wb_dmem_q;
    assign WBAlu           = wb_alu_q;
    assign WBPC            = wb_pc_q;
    assign WBSel           = wb_sel_q;
    assign WB_csr_reg_en   = wb_csr_en_q;
    assign WB_csr_rresult  = wb_csr_val_q;
    assign wb_rd           = wb_rd_q;
    assign wb_reg_wen      = wb_reg_wen_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard bench for mem_access_stage
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_reg_wen, ex_mem_read, ex_mem_write, ex_csr_reg_en, flush;
    logic [31:0] ex_alu_result, ex_store_data, ex_pc, ex_csr_rresult;
    logic [4:0]  ex_rd;
    logic [1:0]  ex_wbsel;
    logic [2:0]  ex_funct3;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        mem_stall, MEM_csr_reg_en, WB_csr_reg_en, wb_reg_wen, misalign_exc, bus_err;
    logic [31:0] MEMAlu, MEM_csr_rresult, WBdmem, WBAlu, WBPC, WB_csr_rresult, exc_addr;
    logic [1:0]  WBSel;
    logic [4:0]  wb_rd;

    mem_access_stage #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
        .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_reg_wen(ex_reg_wen),
        .ex_wbsel(ex_wbsel), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_funct3(ex_funct3), .ex_csr_reg_en(ex_csr_reg_en), .ex_csr_rresult(ex_csr_rresult),
        .flush(flush), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .MEMAlu(MEMAlu), .MEM_csr_reg_en(MEM_csr_reg_en),
        .MEM_csr_rresult(MEM_csr_rresult), .WBdmem(WBdmem), .WBAlu(WBAlu), .WBPC(WBPC),
        .WBSel(WBSel), .WB_csr_reg_en(WB_csr_reg_en), .WB_csr_rresult(WB_csr_rresult),
        .wb_rd(wb_rd), .wb_reg_wen(wb_reg_wen), .misalign_exc(misalign_exc),
        .bus_err(bus_err), .exc_addr(exc_addr)
    );

    always #5 clk = ~clk;

    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; logic chk_wd; } req_t;
    typedef struct { logic [4:0] rd; logic [1:0] sel; logic [31:0] val; } wb_t;
    typedef struct { logic is_bus; logic [31:0] addr; } exc_t;

    req_t req_q[$];
    wb_t  wb_q[$];
    exc_t exc_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] be, input logic chk_wd);
        req_t r;
        r.we = we; r.addr = addr; r.wdata = wd; r.be = be; r.chk_wd = chk_wd;
        req_q.push_back(r);
    endtask

    task automatic exp_wb(input logic [4:0] rd, input logic [1:0] sel, input logic [31:0] val);
        wb_t w;
        w.rd = rd; w.sel = sel; w.val = val;
        wb_q.push_back(w);
    endtask

    task automatic exp_exc(input logic is_bus, input logic [31:0] addr);
        exc_t e;
        e.is_bus = is_bus; e.addr = addr;
        exc_q.push_back(e);
    endtask

    // Monitor: compare every DUT event against the head of the matching queue
    always @(negedge clk) begin
        if (!rst) begin
            if (dmem_req) begin
                if (req_q.size() == 0) begin
                    check("unexpected_req", 96'(dmem_addr), 96'hffff_ffff_ffff);
                end else begin
                    check("req_fields",
                          {dmem_we, dmem_addr, dmem_be, (req_q[0].chk_wd ? dmem_wdata : 32'h0)},
                          {req_q[0].we, req_q[0].addr, req_q[0].be,
                           (req_q[0].chk_wd ? req_q[0].wdata : 32'h0)});
                    if (dmem_ack || bus_err) void'(req_q.pop_front());
                end
            end
            if (wb_reg_wen) begin
                if (wb_q.size() == 0) begin
                    check("unexpected_wb", 96'(wb_rd), 96'hffff_ffff_ffff);
                end else begin
                    check("wb_fields",
                          {wb_rd, WBSel, (WBSel == 2'b00) ? WBdmem : (WBSel == 2'b01) ? WBAlu : WBPC},
                          {wb_q[0].rd, wb_q[0].sel, wb_q[0].val});
                    void'(wb_q.pop_front());
                end
            end
            if (misalign_exc || bus_err) begin
                if (exc_q.size() == 0) begin
                    check("unexpected_exc", {misalign_exc, bus_err, exc_addr}, 96'hffff_ffff_ffff);
                end else begin
                    check("exc_fields", {misalign_exc, bus_err, exc_addr},
                          {~exc_q[0].is_bus, exc_q[0].is_bus, exc_q[0].addr});
                    void'(exc_q.pop_front());
                end
            end
        end
    end

    task automatic clear_ex();
        ex_valid = 0; ex_alu_result = 0; ex_store_data = 0; ex_pc = 0; ex_rd = 0;
        ex_reg_wen = 0; ex_wbsel = 0; ex_mem_read = 0; ex_mem_write = 0; ex_funct3 = 0;
        ex_csr_reg_en = 0; ex_csr_rresult = 0;
    endtask

    task automatic drive_ex(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                            input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                            input logic rwen, input logic [1:0] sel);
        ex_valid = 1; ex_mem_read = rd_op; ex_mem_write = wr_op; ex_funct3 = f3;
        ex_alu_result = alu; ex_store_data = sd; ex_rd = rd; ex_reg_wen = rwen;
        ex_wbsel = sel; ex_pc = alu + 32'h1000;
    endtask

    // One instruction through MEM; ack_lat = cycle index of ack (-1 = never)
    task automatic do_op(input string name, input logic rd_op, input logic wr_op,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [4:0] rd, input logic rwen, input logic [1:0] sel,
                         input int ack_lat, input logic [31:0] rdata, input int exp_stalls,
                         input logic fl);
        int stalls;
        int cyc;
        @(posedge clk); #1;
        drive_ex(rd_op, wr_op, f3, alu, sd, rd, rwen, sel);
        flush = 0;
        @(posedge clk); #1;
        clear_ex();
        dmem_rdata = rdata;
        stalls = 0;
        for (cyc = 0; cyc < 40; cyc++) begin
            dmem_ack = (ack_lat == cyc);
            flush = fl;
            @(negedge clk);
            if (!mem_stall) break;
            stalls++;
            @(posedge clk); #1;
        end
        if (cyc >= 40) check({name, "_stall_bound"}, 96'(cyc), 96'(0));
        check({name, "_stall_cycles"}, 96'(stalls), 96'(exp_stalls));
        @(posedge clk); #1;
        dmem_ack = 0;
        flush = 0;
    endtask

    initial begin
        rst = 1; flush = 0; dmem_ack = 0; dmem_rdata = 0;
        clear_ex();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              {dmem_req, mem_stall, wb_reg_wen, misalign_exc, bus_err, dmem_be, MEMAlu, WBdmem, exc_addr},
              96'h0);
        @(posedge clk); #1;
        rst = 0;

        // SW, zero-wait
        exp_req(1, 32'h100, 32'hDEADBEEF, 4'b1111, 1);
        do_op("sw", 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0, 0, 2'b01, 0, 32'h0, 0, 0);

        // LB with 3 wait cycles, sign extension of byte 3
        exp_req(0, 32'h100, 32'h0, 4'b1111, 0);
        exp_wb(5'd3, 2'b00, 32'hFFFFFF80);
        do_op("lb", 1, 0, 3'b000, 32'h103, 32'h0, 5'd3, 1, 2'b00, 3, 32'h80FF_FF00, 3, 0);

        // LBU byte 1 zero-extended
        exp_req(0, 32'h100, 32'h0, 4'b1111, 0);
        exp_wb(5'd2, 2'b00, 32'h000000FF);
        do_op("lbu", 1, 0, 3'b100, 32'h101, 32'h0, 5'd2, 1, 2'b00, 0, 32'h80FF_FF00, 0, 0);

        // LHU upper half
        exp_req(0, 32'h200, 32'h0, 4'b1111, 0);
        exp_wb(5'd4, 2'b00, 32'h0000BEEF);
        do_op("lhu", 1, 0, 3'b101, 32'h202, 32'h0, 5'd4, 1, 2'b00, 1, 32'hBEEF_1234, 1, 0);

        // LH upper half sign-extended
        exp_req(0, 32'h204, 32'h0, 4'b1111, 0);
        exp_wb(5'd8, 2'b00, 32'hFFFF8001);
        do_op("lh", 1, 0, 3'b001, 32'h206, 32'h0, 5'd8, 1, 2'b00, 0, 32'h8001_7FFF, 0, 0);

        // LH misaligned: no request, exception pulse, no writeback
        exp_exc(0, 32'h201);
        do_op("lh_mis", 1, 0, 3'b001, 32'h201, 32'h0, 5'd5, 1, 2'b00, -1, 32'h0, 0, 0);
        @(negedge clk);
        check("exc_addr_held", 96'(exc_addr), 96'(32'h201));

        // SW misaligned
        exp_exc(0, 32'h102);
        do_op("sw_mis", 0, 1, 3'b010, 32'h102, 32'h11112222, 5'd0, 0, 2'b01, -1, 32'h0, 0, 0);

        // SB / SH lane steering
        exp_req(1, 32'h0C, 32'hABABABAB, 4'b0100, 1);
        do_op("sb", 0, 1, 3'b000, 32'h0E, 32'h000000AB, 5'd0, 0, 2'b01, 0, 32'h0, 0, 0);
        exp_req(1, 32'h0C, 32'h12341234, 4'b1100, 1);
        do_op("sh", 0, 1, 3'b001, 32'h0E, 32'h00001234, 5'd0, 0, 2'b01, 2, 32'h0, 2, 0);

        // LW with no ack: 16 stall cycles then bus error, no writeback
        exp_req(0, 32'h400, 32'h0, 4'b1111, 0);
        exp_exc(1, 32'h400);
        do_op("lw_timeout", 1, 0, 3'b010, 32'h400, 32'h0, 5'd6, 1, 2'b00, -1, 32'h0, 16, 0);

        // Back in IDLE: zero-wait store
        exp_req(1, 32'h10, 32'hCAFEF00D, 4'b1111, 1);
        do_op("sw_after_to", 0, 1, 3'b010, 32'h10, 32'hCAFEF00D, 5'd0, 0, 2'b01, 0, 32'h0, 0, 0);

        // Flush held high during a BUSY stall: load still completes
        exp_req(0, 32'h500, 32'h0, 4'b1111, 0);
        exp_wb(5'd7, 2'b00, 32'h0BADF00D);
        do_op("lw_flush", 1, 0, 3'b010, 32'h500, 32'h0, 5'd7, 1, 2'b00, 2, 32'h0BADF00D, 2, 1);

        // ALU op writes back through WBAlu
        exp_wb(5'd9, 2'b01, 32'h12345678);
        do_op("alu", 0, 0, 3'b000, 32'h12345678, 32'h0, 5'd9, 1, 2'b01, -1, 32'h0, 0, 0);

        // Flush with no stall: bubble in MEM, forward value unchanged, no request
        @(posedge clk); #1;
        drive_ex(0, 1, 3'b010, 32'h300, 32'h77777777, 5'd10, 1, 2'b01);
        flush = 1;
        @(posedge clk); #1;
        clear_ex();
        flush = 0;
        @(negedge clk);
        check("flush_memalu", 96'(MEMAlu), 96'(32'h12345678));
        check("flush_no_req", 96'(dmem_req), 96'(0));
        repeat (2) @(posedge clk);

        // Reset while BUSY: request drops, no bus error follows
        @(posedge clk); #1;
        drive_ex(1, 0, 3'b010, 32'h600, 32'h0, 5'd11, 1, 2'b00);
        exp_req(0, 32'h600, 32'h0, 4'b1111, 0);
        @(posedge clk); #1;
        clear_ex();
        dmem_ack = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;
        rst = 0;
        req_q.delete();
        @(negedge clk);
        check("rst_busy", {dmem_req, mem_stall, bus_err}, 96'h0);
        repeat (20) @(posedge clk);

        // Recovery after reset
        exp_req(1, 32'h20, 32'h00000055, 4'b1111, 1);
        do_op("sw_after_rst", 0, 1, 3'b010, 32'h20, 32'h00000055, 5'd0, 0, 2'b01, 0, 32'h0, 0, 0);

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("req_q_drained", 96'(req_q.size()), 96'(0));
        check("wb_q_drained", 96'(wb_q.size()), 96'(0));
        check("exc_q_drained", 96'(exc_q.size()), 96'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
